// File: rtl/obi_rr_mux.sv
// obi_rr_mux: N-to-1 OBI mux with round-robin arbitration, request lock and in-order response routing
module obi_rr_mux #(
    parameter int unsigned NR_MASTERS      = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NR_MASTERS-1:0]                    m_req_i,
    input  logic [NR_MASTERS-1:0]                    m_we_i,
    input  logic [NR_MASTERS*ADDR_WIDTH-1:0]         m_addr_i,
    input  logic [NR_MASTERS*DATA_WIDTH/8-1:0]       m_be_i,
    input  logic [NR_MASTERS*DATA_WIDTH-1:0]         m_wdata_i,
    output logic [NR_MASTERS-1:0]                    m_gnt_o,
    output logic [NR_MASTERS-1:0]                    m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    m_rdata_o,
    output logic                                     s_req_o,
    output logic                                     s_we_o,
    output logic [ADDR_WIDTH-1:0]                    s_addr_o,
    output logic [DATA_WIDTH/8-1:0]                  s_be_o,
    output logic [DATA_WIDTH-1:0]                    s_wdata_o,
    input  logic                                     s_gnt_i,
    input  logic                                     s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     protocol_err_o
);
    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned IW = $clog2(NR_MASTERS);
    localparam int unsigned PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IW-1:0] LAST_M = IW'(NR_MASTERS - 1);
    localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] FULL_C = CW'(MAX_OUTSTANDING);

    function automatic logic [IW-1:0] inc_m(input logic [IW-1:0] i);
        return (i == LAST_M) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [PW-1:0] inc_p(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    logic [ADDR_WIDTH-1:0] addr_arr  [NR_MASTERS];
    logic [BW-1:0]         be_arr    [NR_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [NR_MASTERS];
    logic [IW-1:0]         fifo      [MAX_OUTSTANDING];
    logic [IW-1:0] prio, lock_idx, arb_idx, sel_idx, cand, head;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic lock, any_req, sel_req, full, hs, pop, lock_viol, underflow, err;

    for (genvar g = 0; g < NR_MASTERS; g++) begin : g_unpack
        assign addr_arr[g]  = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign be_arr[g]    = m_be_i[g*BW +: BW];
        assign wdata_arr[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // first requester at or after prio, wrapping around
    always_comb begin
        cand    = prio;
        arb_idx = '0;
        any_req = 1'b0;
        for (int k = 0; k < NR_MASTERS; k++) begin
            if (!any_req && m_req_i[cand]) begin
                any_req = 1'b1;
                arb_idx = cand;
            end
            cand = inc_m(cand);
        end
    end

    assign sel_idx   = lock ? lock_idx : arb_idx;
    assign sel_req   = lock ? m_req_i[lock_idx] : any_req;
    assign full      = cnt == FULL_C;
    assign s_req_o   = rst_ni & sel_req & ~full;
    assign hs        = s_req_o & s_gnt_i;
    assign pop       = s_rvalid_i & (cnt != '0);
    assign underflow = s_rvalid_i & (cnt == '0);
    assign lock_viol = lock & ~m_req_i[lock_idx];
    assign head      = fifo[rptr];

    assign s_we_o        = s_req_o & m_we_i[sel_idx];
    assign s_addr_o      = s_req_o ? addr_arr[sel_idx] : '0;
    assign s_be_o        = s_req_o ? be_arr[sel_idx] : '0;
    assign s_wdata_o     = s_req_o ? wdata_arr[sel_idx] : '0;
    assign m_gnt_o       = hs ? NR_MASTERS'(1'b1) << sel_idx : '0;
    assign m_rvalid_o    = pop ? NR_MASTERS'(1'b1) << head : '0;
    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = cnt;
    assign protocol_err_o = err;

    always_ff @(posedge clk_i) begin
        if (hs) fifo[wptr] <= sel_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio     <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            if (hs) begin
                prio <= inc_m(sel_idx);
                wptr <= inc_p(wptr);
            end
            if (pop) rptr <= inc_p(rptr);
            cnt <= cnt + CW'(hs) - CW'(pop);
            if (hs) begin
                lock <= 1'b0;
            end else if (s_req_o) begin
                lock     <= 1'b1;
                lock_idx <= sel_idx;
            end else if (lock_viol) begin
                lock <= 1'b0;
            end
            if (lock_viol || underflow) err <= 1'b1;
        end
    end
endmodule
